// File: rtl/register_file_wb_if.sv
// Bus bundle between the pipeline (master) and the Y86-64 register file (slave):
// write-back inputs, decode read ports, debug read port and machine status.
interface register_file_wb_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic [3:0]        w_stat;
    logic [3:0]        w_icode;
    logic [3:0]        w_dstE;
    logic [DATA_W-1:0] w_valE;
    logic [3:0]        w_dstM;
    logic [DATA_W-1:0] w_valM;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [DATA_W-1:0] d_rvalA;
    logic [DATA_W-1:0] d_rvalB;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;
    logic              halted;
    logic [3:0]        halt_stat;
    logic [CNT_W-1:0]  retired;

    modport master (
        output w_stat, w_icode, w_dstE, w_valE, w_dstM, w_valM,
        output d_srcA, d_srcB, dbg_sel,
        input  d_rvalA, d_rvalB, dbg_data, halted, halt_stat, retired
    );

    modport slave (
        input  w_stat, w_icode, w_dstE, w_valE, w_dstM, w_valM,
        input  d_srcA, d_srcB, dbg_sel,
        output d_rvalA, d_rvalB, dbg_data, halted, halt_stat, retired
    );
endinterface

// File: rtl/register_file_wb.sv
// Y86-64 register file with write-back bypass, sticky halt on a non-AOK retire,
// a retired-instruction counter and a registered debug read port.
module register_file_wb #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int CNT_W  = 32
) (
    input logic              clk,
    input logic              reset,
    register_file_wb_if.slave bus
);
    localparam logic [3:0] RNONE     = 4'hF;
    localparam logic [3:0] STAT_AOK  = 4'd1;
    localparam logic [3:0] STAT_HLT  = 4'd2;
    localparam logic [3:0] STAT_ADR  = 4'd3;
    localparam logic [3:0] STAT_INS  = 4'd4;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [3:0]        halt_stat_q, halt_stat_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              commit, we_e, we_m, halted;
    logic [DATA_W-1:0] rval_a, rval_b;

    always_comb begin
        commit = (state_q == RUN) && (bus.w_stat == STAT_AOK);
        we_e   = commit && (bus.w_dstE != RNONE);
        we_m   = commit && (bus.w_dstM != RNONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.w_stat != STAT_AOK) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        halted = (state_q == HALTED);
    end

    // M is applied after E so it wins when both target the same register (popq %rsp).
    always_comb begin
        regs_d = regs_q;
        if (we_e) regs_d[bus.w_dstE] = bus.w_valE;
        if (we_m) regs_d[bus.w_dstM] = bus.w_valM;
    end

    always_comb begin
        halt_stat_d = halt_stat_q;
        if ((state_q == RUN) && (bus.w_stat != STAT_AOK)) begin
            case (bus.w_stat)
                STAT_HLT, STAT_ADR, STAT_INS: halt_stat_d = bus.w_stat;
                default:                      halt_stat_d = STAT_INS;
            endcase
        end
        retired_d = retired_q;
        if (commit && (bus.w_icode != ICODE_NOP)) retired_d = retired_q + CNT_W'(1);
        dbg_data_d = (bus.dbg_sel == RNONE) ? '0 : regs_q[bus.dbg_sel];
    end

    always_comb begin
        rval_a = '0;
        if (bus.d_srcA == RNONE)                      rval_a = '0;
        else if (we_m && (bus.d_srcA == bus.w_dstM)) rval_a = bus.w_valM;
        else if (we_e && (bus.d_srcA == bus.w_dstE)) rval_a = bus.w_valE;
        else                                          rval_a = regs_q[bus.d_srcA];
        rval_b = '0;
        if (bus.d_srcB == RNONE)                      rval_b = '0;
        else if (we_m && (bus.d_srcB == bus.w_dstM)) rval_b = bus.w_valM;
        else if (we_e && (bus.d_srcB == bus.w_dstE)) rval_b = bus.w_valE;
        else                                          rval_b = regs_q[bus.d_srcB];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            halt_stat_q <= STAT_AOK;
            retired_q   <= '0;
            dbg_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            halt_stat_q <= halt_stat_d;
            retired_q   <= retired_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

    assign bus.d_rvalA   = rval_a;
    assign bus.d_rvalB   = rval_b;
    assign bus.dbg_data  = dbg_data_q;
    assign bus.halted    = halted;
    assign bus.halt_stat = halt_stat_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_register_file_wb.sv
// Scoreboard bench for register_file_wb: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is observable.
module tb_register_file_wb;
    logic clk;
    logic reset;

    register_file_wb_if #(.DATA_W(64), .CNT_W(32)) bus ();

    register_file_wb #(.DATA_W(64), .NREG(15), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic [3:0] stat, input logic [3:0] icode,
                            input logic [3:0] dst_e, input logic [63:0] val_e,
                            input logic [3:0] dst_m, input logic [63:0] val_m);
        bus.w_stat  = stat;
        bus.w_icode = icode;
        bus.w_dstE  = dst_e;
        bus.w_valE  = val_e;
        bus.w_dstM  = dst_m;
        bus.w_valM  = val_m;
    endtask

    task automatic drive_idle();
        drive_wb(4'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 15; s++) begin
            bus.dbg_sel = 4'(s);
            sb.push_back('{$sformatf("reset_dbg%0d", s), 64'h0});
            tick();
            e = sb.pop_front(); n_checks++;
            if (bus.dbg_data !== e.val) begin
                n_errors++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, bus.dbg_data, e.val);
            end
        end
        bus.dbg_sel = 4'hF;
        sb.push_back('{"reset_halted", 64'd0});
        sb.push_back('{"reset_halt_stat", 64'd1});
        sb.push_back('{"reset_retired", 64'd0});
        e = sb.pop_front(); n_checks++;
        if (bus.halted !== e.val[0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halted, e.val[0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.halt_stat !== e.val[3:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halt_stat, e.val[3:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
    endtask

    task automatic test_write_bypass();
        drive_wb(4'd1, 4'h6, 4'h0, 64'd5, 4'h3, 64'd7);
        bus.d_srcA = 4'h0;
        bus.d_srcB = 4'h3;
        sb.push_back('{"bypass_E_srcA", 64'd5});
        sb.push_back('{"bypass_M_srcB", 64'd7});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        tick();
        drive_idle();
        sb.push_back('{"stored_reg0", 64'd5});
        sb.push_back('{"stored_reg3", 64'd7});
        sb.push_back('{"retired_after_first", 64'd1});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
    endtask

    task automatic test_same_dst();
        drive_wb(4'd1, 4'hB, 4'h4, 64'd1, 4'h4, 64'd2);
        bus.d_srcA = 4'h4;
        sb.push_back('{"same_dst_bypass", 64'd2});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        tick();
        drive_idle();
        bus.dbg_sel = 4'h4;
        sb.push_back('{"same_dst_reg4", 64'd2});
        sb.push_back('{"same_dst_dbg4", 64'd2});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        tick();
        e = sb.pop_front(); n_checks++;
        if (bus.dbg_data !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.dbg_data, e.val);
        end
    endtask

    task automatic test_dst_none();
        drive_wb(4'd1, 4'h6, 4'hF, 64'hFFFF, 4'hF, 64'hEEEE);
        bus.d_srcA = 4'hF;
        sb.push_back('{"rnone_read_zero", 64'd0});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        tick();
        drive_idle();
        bus.d_srcA  = 4'h0;
        bus.d_srcB  = 4'h3;
        bus.dbg_sel = 4'h4;
        sb.push_back('{"rnone_keep_reg0", 64'd5});
        sb.push_back('{"rnone_keep_reg3", 64'd7});
        sb.push_back('{"rnone_retired", 64'd3});
        sb.push_back('{"rnone_keep_reg4", 64'd2});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
        tick();
        e = sb.pop_front(); n_checks++;
        if (bus.dbg_data !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.dbg_data, e.val);
        end
    endtask

    task automatic test_halt();
        drive_wb(4'd2, 4'h0, 4'h1, 64'd9, 4'hF, 64'h0);
        bus.d_srcA = 4'h1;
        sb.push_back('{"halt_no_bypass", 64'd0});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        tick();
        drive_wb(4'd1, 4'h6, 4'h1, 64'h55, 4'h0, 64'h66);
        sb.push_back('{"halted_flag", 64'd1});
        sb.push_back('{"halt_stat_hlt", 64'd2});
        sb.push_back('{"halted_no_bypass", 64'd0});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.halted !== e.val[0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halted, e.val[0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.halt_stat !== e.val[3:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halt_stat, e.val[3:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        tick();
        drive_idle();
        bus.d_srcB  = 4'h0;
        bus.dbg_sel = 4'h0;
        sb.push_back('{"halted_reg1_kept", 64'd0});
        sb.push_back('{"halted_reg0_kept", 64'd5});
        sb.push_back('{"halted_retired_frozen", 64'd3});
        sb.push_back('{"halted_dbg_reg0", 64'd5});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
        tick();
        e = sb.pop_front(); n_checks++;
        if (bus.dbg_data !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.dbg_data, e.val);
        end
    endtask

    task automatic test_reset_while_halted();
        reset = 1'b1;
        drive_wb(4'd1, 4'h6, 4'h2, 64'h77, 4'hF, 64'h0);
        tick();
        reset = 1'b0;
        drive_idle();
        bus.d_srcA = 4'h0;
        bus.d_srcB = 4'h2;
        sb.push_back('{"rst_halted_clear", 64'd0});
        sb.push_back('{"rst_halt_stat", 64'd1});
        sb.push_back('{"rst_retired", 64'd0});
        sb.push_back('{"rst_reg0_clear", 64'd0});
        sb.push_back('{"rst_wins_reg2", 64'd0});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.halted !== e.val[0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halted, e.val[0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.halt_stat !== e.val[3:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halt_stat, e.val[3:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        drive_wb(4'd1, 4'h3, 4'h2, 64'hABC, 4'hF, 64'h0);
        tick();
        drive_idle();
        sb.push_back('{"post_rst_reg2", 64'hABC});
        sb.push_back('{"post_rst_retired", 64'd1});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_wb(4'd1, 4'h6, 4'h5, 64'h11, 4'hF, 64'h0);   tick();
        drive_wb(4'd1, 4'h5, 4'hF, 64'h0, 4'h6, 64'h22);   tick();
        drive_wb(4'd1, 4'hB, 4'h4, 64'h100, 4'h7, 64'h33); tick();
        drive_wb(4'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);    tick();
        drive_wb(4'd1, 4'h1, 4'h5, 64'h99, 4'hF, 64'h0);   tick();
        drive_wb(4'd3, 4'h6, 4'h5, 64'hDEAD, 4'hF, 64'h0);
        sb.push_back('{"stream_retired", 64'd3});
        sb.push_back('{"stream_halt_stat_adr", 64'd3});
        sb.push_back('{"stream_nop_wrote_reg5", 64'h99});
        sb.push_back('{"stream_reg6", 64'h22});
        tick();
        drive_idle();
        bus.d_srcA = 4'h5;
        bus.d_srcB = 4'h6;
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.retired !== e.val[31:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.retired, e.val[31:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.halt_stat !== e.val[3:0]) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halt_stat, e.val[3:0]);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
        bus.d_srcA = 4'h7;
        bus.d_srcB = 4'h4;
        sb.push_back('{"stream_popq_reg7", 64'h33});
        sb.push_back('{"stream_popq_reg4", 64'h100});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalB !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalB, e.val);
        end
    endtask

    task automatic test_invalid_stat();
        logic [3:0] bad_stats [3];
        bad_stats[0] = 4'd0;
        bad_stats[1] = 4'd5;
        bad_stats[2] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            drive_wb(bad_stats[k], 4'h6, 4'h2, 64'h7, 4'hF, 64'h0);
            sb.push_back('{$sformatf("invalid_stat%0d_as_ins", bad_stats[k]), 64'd4});
            tick();
            drive_idle();
            e = sb.pop_front(); n_checks++;
            if (bus.halt_stat !== e.val[3:0]) begin
                n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.halt_stat, e.val[3:0]);
            end
        end
        bus.d_srcA = 4'h2;
        sb.push_back('{"invalid_no_write", 64'd0});
        #1;
        e = sb.pop_front(); n_checks++;
        if (bus.d_rvalA !== e.val) begin
            n_errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, bus.d_rvalA, e.val);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.d_srcA  = 4'hF;
        bus.d_srcB  = 4'hF;
        bus.dbg_sel = 4'hF;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;

        test_reset();
        test_write_bypass();
        test_same_dst();
        test_dst_none();
        test_halt();
        test_reset_while_halted();
        test_back_to_back();
        test_invalid_stat();

        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
